// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone timer: register map, CTRL layout and byte-lane merge.
package wb_timer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = DATA_W / 8;
  localparam int unsigned ADR_W  = 2;

  typedef enum logic [ADR_W-1:0] {
    TMR_CTRL     = 2'd0,
    TMR_PRESCALE = 2'd1,
    TMR_COUNT    = 2'd2,
    TMR_COMPARE  = 2'd3
  } tmr_reg_e;

  localparam int unsigned CTRL_EN          = 0;
  localparam int unsigned CTRL_AUTO_RELOAD = 1;
  localparam int unsigned CTRL_IRQ_EN      = 2;
  localparam int unsigned CTRL_IRQ_PEND    = 3;

  typedef struct packed {
    logic irq_pend;
    logic irq_en;
    logic auto_reload;
    logic en;
  } tmr_ctrl_t;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [SEL_W-1:0]  sel);
    logic [DATA_W-1:0] merged;
    merged = old_val;
    for (int i = 0; i < SEL_W; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Prescaler: counts 0..i_div while enabled and pulses o_tick_c on the terminal value.
module wb_timer_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [PRESCALE_W-1:0] i_div,
  output logic                  o_tick_c
);

  logic [PRESCALE_W-1:0] r_cnt;

  assign o_tick_c = i_en && (r_cnt == i_div);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/wb_timer.sv
// Wishbone slave timer: prescaled 32-bit up-counter with compare match, auto-reload and level IRQ.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int unsigned       PRESCALE_W = 16,
  parameter logic [DATA_W-1:0] CMP_RESET  = 32'hFFFF_FFFF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [ADR_W-1:0]  wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic              wb_we_i,
  input  logic [SEL_W-1:0]  wb_sel_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic              irq_o
);

  tmr_ctrl_t             r_ctrl;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [DATA_W-1:0]     r_count;
  logic [DATA_W-1:0]     r_compare;

  tmr_reg_e          w_reg;
  logic              w_acc;
  logic              w_wr;
  logic              w_wr_ctrl;
  logic              w_wr_pre;
  logic              w_wr_cnt;
  logic              w_wr_cmp;
  logic              w_tick;
  logic              w_match;
  logic              w_pend_set;
  logic              w_pend_clr;
  logic [DATA_W-1:0] w_rdata;

  // An access is taken only while not already acking, so a held strobe commits once per ack.
  assign w_reg     = tmr_reg_e'(wb_adr_i);
  assign w_acc     = wb_stb_i & ~wb_ack_o;
  assign w_wr      = w_acc & wb_we_i;
  assign w_wr_ctrl = w_wr & (w_reg == TMR_CTRL);
  assign w_wr_pre  = w_wr & (w_reg == TMR_PRESCALE);
  assign w_wr_cnt  = w_wr & (w_reg == TMR_COUNT);
  assign w_wr_cmp  = w_wr & (w_reg == TMR_COMPARE);

  // A software COUNT write suppresses the match; hardware set beats the W1C.
  assign w_match    = (r_count == r_compare);
  assign w_pend_set = w_tick & w_match & ~w_wr_cnt;
  assign w_pend_clr = w_wr_ctrl & wb_sel_i[0] & wb_dat_i[CTRL_IRQ_PEND];

  assign irq_o = r_ctrl.irq_pend & r_ctrl.irq_en;

  wb_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .i_clk    (wb_clk_i),
    .i_rst_n  (wb_rst_i),
    .i_en     (r_ctrl.en),
    .i_clr    (w_wr_pre | w_wr_cnt),
    .i_div    (r_prescale),
    .o_tick_c (w_tick)
  );

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      TMR_CTRL:     w_rdata = DATA_W'(r_ctrl);
      TMR_PRESCALE: w_rdata = DATA_W'(r_prescale);
      TMR_COUNT:    w_rdata = r_count;
      TMR_COMPARE:  w_rdata = r_compare;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_count    <= '0;
      r_compare  <= CMP_RESET;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
    end else begin
      wb_ack_o <= w_acc;
      if (w_acc) wb_dat_o <= w_rdata;

      if (w_wr_ctrl && wb_sel_i[0]) begin
        r_ctrl.en          <= wb_dat_i[CTRL_EN];
        r_ctrl.auto_reload <= wb_dat_i[CTRL_AUTO_RELOAD];
        r_ctrl.irq_en      <= wb_dat_i[CTRL_IRQ_EN];
      end
      r_ctrl.irq_pend <= w_pend_set | (r_ctrl.irq_pend & ~w_pend_clr);

      if (w_wr_pre) r_prescale <= PRESCALE_W'(byte_merge(DATA_W'(r_prescale), wb_dat_i, wb_sel_i));
      if (w_wr_cmp) r_compare  <= byte_merge(r_compare, wb_dat_i, wb_sel_i);

      if (w_wr_cnt) begin
        r_count <= byte_merge(r_count, wb_dat_i, wb_sel_i);
      end else if (w_tick) begin
        r_count <= (w_match && r_ctrl.auto_reload) ? '0 : r_count + DATA_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: scoreboarded register reads plus cycle-exact timing checks.
module tb_wb_timer;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_PRE  = 2'd1;
  localparam logic [1:0] A_CNT  = 2'd2;
  localparam logic [1:0] A_CMP  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        ack;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int irq_rise = -1;
  logic irq_prev = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  string       nm_q[$];

  always #5 clk = ~clk;

  wb_timer #(
    .PRESCALE_W (16),
    .CMP_RESET  (32'hFFFF_FFFF)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wb_adr_i (adr),
    .wb_dat_i (dat_i),
    .wb_dat_o (dat_o),
    .wb_we_i  (we),
    .wb_sel_i (sel),
    .wb_stb_i (stb),
    .wb_ack_o (ack),
    .irq_o    (irq)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Edge index that produced the first rising irq.
  always @(negedge clk) begin
    if (irq === 1'b1 && irq_prev !== 1'b1 && irq_rise < 0) irq_rise = cyc;
    irq_prev = irq;
  end

  task automatic wb_xfer(input logic [1:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
    int n;
    @(negedge clk);
    adr = a; we = w; sel = s; dat_i = d; stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (ack !== 1'b1 && n < 8);
    acc_cyc = cyc;
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL ack latency adr=%0d: got %0d cycles, expected 1", a, n);
    end
    if (!w) got_q.push_back(ack === 1'b1 ? dat_o : 32'hxxxx_xxxx);
    @(negedge clk);
    stb = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL ack width adr=%0d: ack=%b one cycle after ack, expected 0", a, ack);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
    wb_xfer(a, 1'b1, s, d);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    wb_xfer(a, 1'b0, 4'hF, 32'h0);
  endtask

  task automatic test_reset(input logic hold_stb, input string tag);
    logic [31:0] e, g;
    string nm;
    @(negedge clk);
    rst_n = 1'b0; stb = hold_stb; we = 1'b0; adr = A_CNT; sel = 4'hF; dat_i = '0;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0 || irq !== 1'b0) begin
        errors++;
        $display("FAIL %s in reset: ack=%b irq=%b, expected 0 0", tag, ack, irq);
      end
    end
    checks++;
    if (dat_o !== 32'h0) begin
      errors++;
      $display("FAIL %s dat_o after reset: got %h expected 00000000", tag, dat_o);
    end
    @(negedge clk);
    rst_n = 1'b1; stb = 1'b0;
    rd(A_CTRL, 32'h0, {tag, " ctrl"});
    rd(A_PRE,  32'h0, {tag, " prescale"});
    rd(A_CNT,  32'h0, {tag, " count"});
    rd(A_CMP,  32'hFFFF_FFFF, {tag, " compare"});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, g, e); end
    end
  endtask

  task automatic test_periodic();
    logic [31:0] e, g;
    string nm;
    int c0;
    wr(A_PRE, 4'hF, 32'd3);
    wr(A_CMP, 4'hF, 32'd4);
    wr(A_CNT, 4'hF, 32'd0);
    wr(A_CTRL, 4'hF, 32'h7);
    c0 = acc_cyc;
    for (int k = 0; k < 6; k++) begin
      rd(A_CNT, (k < 5) ? 32'(k) : 32'd0, $sformatf("periodic count[%0d]", k));
      repeat (2) @(posedge clk);
    end
    rd(A_CTRL, 32'hF, "periodic ctrl pend");
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL periodic irq high: got %b expected 1", irq); end
    checks++;
    if (irq_rise - c0 != 20) begin
      errors++;
      $display("FAIL periodic irq delay: got %0d cycles expected 20", irq_rise - c0);
    end
    wr(A_CTRL, 4'hF, 32'hF);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL periodic irq after W1C: got %b expected 0", irq); end
    wr(A_CTRL, 4'hF, 32'h8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, g, e); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e, g;
    string nm;
    wr(A_CNT, 4'hF, 32'hFFFF_FFFE);
    wr(A_CMP, 4'hF, 32'd5);
    wr(A_PRE, 4'hF, 32'd0);
    wr(A_CTRL, 4'hF, 32'h1);
    @(posedge clk);
    rd(A_CNT,  32'h0, "wrap count after 2 ticks");
    rd(A_CTRL, 32'h1, "wrap no pend after wrap");
    rd(A_CTRL, 32'h1, "wrap no pend before match");
    rd(A_CTRL, 32'h9, "wrap pend after 6 ticks");
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL wrap irq masked: got %b expected 0", irq); end
    wr(A_CTRL, 4'hF, 32'h8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, g, e); end
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] e, g;
    string nm;
    wr(A_CMP, 4'hF, 32'hFFFF_FFFF);
    wr(A_CMP, 4'b0101, 32'hAABB_CCDD);
    rd(A_CMP, 32'hFFBB_FFDD, "sel compare");
    wr(A_PRE, 4'hF, 32'h1234_5678);
    rd(A_PRE, 32'h0000_5678, "sel prescale width");
    wr(A_CNT, 4'hF, 32'h0);
    wr(A_CNT, 4'b1000, 32'h12AB_CDEF);
    rd(A_CNT, 32'h1200_0000, "sel count top byte");
    wr(A_CTRL, 4'hF, 32'hFFFF_FFF0);
    rd(A_CTRL, 32'h0, "ctrl reserved bits");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, g, e); end
    end
  endtask

  task automatic test_collisions();
    logic [31:0] e, g;
    string nm;
    // W1C lands on the match edge: tick 11 sees COUNT==10.
    wr(A_PRE, 4'hF, 32'd0);
    wr(A_CMP, 4'hF, 32'd10);
    wr(A_CNT, 4'hF, 32'd0);
    wr(A_CTRL, 4'hF, 32'h1);
    repeat (9) @(posedge clk);
    wr(A_CTRL, 4'hF, 32'h9);
    rd(A_CTRL, 32'h9, "collide set beats W1C");
    wr(A_CTRL, 4'hF, 32'h8);
    rd(A_CTRL, 32'h0, "collide plain W1C");
    // COUNT write lands on a matching tick (PRESCALE=3, second tick at +8).
    wr(A_PRE, 4'hF, 32'd3);
    wr(A_CMP, 4'hF, 32'd1);
    wr(A_CNT, 4'hF, 32'd0);
    wr(A_CTRL, 4'hF, 32'h1);
    repeat (6) @(posedge clk);
    wr(A_CNT, 4'hF, 32'h100);
    rd(A_CNT, 32'h100, "collide count write wins");
    rd(A_CTRL, 32'h1, "collide no match on write");
    wr(A_CTRL, 4'hF, 32'h8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, g, e); end
    end
  endtask

  task automatic test_held_strobe();
    logic [31:0] e, g;
    string nm;
    logic exp_ack;
    wr(A_CNT, 4'hF, 32'h0);
    @(negedge clk);
    adr = A_CNT; we = 1'b1; sel = 4'hF; dat_i = 32'h1; stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      exp_ack = (i % 2 == 0);
      checks++;
      if (ack !== exp_ack) begin
        errors++;
        $display("FAIL held strobe ack cycle %0d: got %b expected %b", i + 1, ack, exp_ack);
      end
    end
    @(negedge clk);
    stb = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL held strobe release: ack=%b expected 0", ack); end
    rd(A_CNT,  32'h1, "held count");
    rd(A_CTRL, 32'h0, "held ctrl untouched");
    rd(A_PRE,  32'd3, "held prescale untouched");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, g, e); end
    end
  endtask

  task automatic test_reset_dirty();
    wr(A_PRE, 4'hF, 32'd0);
    wr(A_CMP, 4'hF, 32'd2);
    wr(A_CNT, 4'hF, 32'd0);
    wr(A_CTRL, 4'hF, 32'h7);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL dirty irq before reset: got %b expected 1", irq); end
    test_reset(1'b1, "reset dirty");
  endtask

  initial begin
    rst_n = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_i = '0;
    test_reset(1'b0, "reset");
    test_periodic();
    test_wrap();
    test_byte_enables();
    test_collisions();
    test_held_strobe();
    test_reset_dirty();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
